// File: rtl/y_weight_filter.sv
// y_weight_filter: 4-tap vertical polyphase filter, 3-stage valid/ready pipeline.
//   S1 registers the four signed tap products, S2 the signed sum, and S3 the
//   shifted, clamped output pixel.
//   Optional build macro Y_WEIGHT_ROUND_EN: adds a round-half-up offset before
//   the shift. Without the macro the shift truncates (floor).
module y_weight_filter #(
    parameter int IN_W    = 15,
    parameter int FRAC_IN = 7,
    parameter int OUT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_0,
    input  logic [IN_W-1:0]  in_1,
    input  logic [IN_W-1:0]  in_2,
    input  logic [IN_W-1:0]  in_3,
    input  logic [1:0]       phase,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] weight_sum
);

    localparam int PW = IN_W + 9;
    localparam int SW = IN_W + 11;
    localparam int SH = FRAC_IN + 7;
    localparam logic signed [SW-1:0] MAX_C = {{(SW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
`ifdef Y_WEIGHT_ROUND_EN
    localparam logic signed [SW-1:0] RND_C = {{(SW-1){1'b0}}, 1'b1} << (FRAC_IN + 6);
`endif

    // Coefficient set {c3,c2,c1,c0}; 9-bit signed fields because +128 does not fit in 8.
    function automatic logic [35:0] coef_set_f(input logic [1:0] ph);
        logic [35:0] set_v;
        case (ph)
            2'd0:    set_v = {9'sd0,    9'sd0,   9'sd128, 9'sd0};
            2'd1:    set_v = {-9'sd3,   9'sd29,  9'sd111, -9'sd9};
            2'd2:    set_v = {-9'sd8,   9'sd72,  9'sd72,  -9'sd8};
            2'd3:    set_v = {-9'sd9,   9'sd111, 9'sd29,  -9'sd3};
            default: set_v = {9'sd0,    9'sd0,   9'sd128, 9'sd0};
        endcase
        return set_v;
    endfunction

    logic                    v1_r, v2_r, v3_r;
    logic                    load2_s, load3_s;
    logic [IN_W-1:0]         tap_s [4];
    logic [35:0]             coef_s;
    logic signed [PW-1:0]    prod_s [4];
    logic signed [PW-1:0]    prod_r [4];
    logic signed [SW-1:0]    sum_s;
    logic signed [SW-1:0]    sum_r;
    logic signed [SW-1:0]    rnd_s;
    logic signed [SW-1:0]    shift_s;
    logic [OUT_W-1:0]        clamp_s;

    // Handshake: each stage may load when it is empty or its content moves on.
    // in_ready is held low while reset is asserted.
    always_comb begin
        load3_s  = !v3_r || out_ready;
        load2_s  = !v2_r || load3_s;
        in_ready = rst && (!v1_r || load2_s);
    end

    // S1 datapath: multiply each tap (zero-extended) by its phase coefficient.
    always_comb begin
        tap_s[0] = in_0;
        tap_s[1] = in_1;
        tap_s[2] = in_2;
        tap_s[3] = in_3;
        coef_s   = coef_set_f(phase);
        for (int k = 0; k < 4; k++) begin
            prod_s[k] = PW'($signed({1'b0, tap_s[k]})) * PW'($signed(coef_s[9*k +: 9]));
        end
    end

    // S2 datapath: signed sum of the four registered products.
    always_comb begin
        sum_s = SW'(prod_r[0]) + SW'(prod_r[1]) + SW'(prod_r[2]) + SW'(prod_r[3]);
    end

    // S3 datapath: optional rounding offset, arithmetic shift, clamp to output range.
    always_comb begin
`ifdef Y_WEIGHT_ROUND_EN
        rnd_s = sum_r + RND_C;
`else
        rnd_s = sum_r;
`endif
        shift_s = rnd_s >>> SH;
        if (shift_s[SW-1]) begin
            clamp_s = {OUT_W{1'b0}};
        end else if (shift_s > MAX_C) begin
            clamp_s = {OUT_W{1'b1}};
        end else begin
            clamp_s = shift_s[OUT_W-1:0];
        end
    end

    // Stage valid bits; cleared asynchronously so in-flight results are discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else begin
            if (in_ready) begin
                v1_r <= in_valid;
            end
            if (load2_s) begin
                v2_r <= v1_r;
            end
            if (load3_s) begin
                v3_r <= v2_r;
            end
        end
    end

    // S1/S2 data registers; no reset needed since the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            prod_r <= prod_s;
        end
        if (load2_s && v1_r) begin
            sum_r <= sum_s;
        end
    end

    // S3 output register; holds its value while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weight_sum <= {OUT_W{1'b0}};
        end else if (load3_s && v2_r) begin
            weight_sum <= clamp_s;
        end
    end

    assign out_valid = v3_r;

endmodule

// File: tb/tb_y_weight_filter.sv
// Self-checking bench for y_weight_filter: directed latency/value cases plus
// randomized streaming against a behavioural queue model.
module tb_y_weight_filter;

    localparam int IN_W    = 15;
    localparam int FRAC_IN = 7;
    localparam int OUT_W   = 8;
    localparam int MAXO    = (1 << OUT_W) - 1;
    localparam int TMAX    = (1 << IN_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_0 = '0, in_1 = '0, in_2 = '0, in_3 = '0;
    logic [1:0]       phase = 2'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] weight_sum;

    int tests = 0;
    int fails = 0;
    int pops  = 0;
    int exp_q[$];
    bit stall_pend = 1'b0;
    logic [OUT_W-1:0] stall_val;

    y_weight_filter #(.IN_W(IN_W), .FRAC_IN(FRAC_IN), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3), .phase(phase),
        .out_valid(out_valid), .out_ready(out_ready), .weight_sum(weight_sum)
    );

    always #5 clk = ~clk;

    // Reference: weighted sum, divide by 2^(FRAC_IN+7) with floor, clamp.
    function automatic int model_f(int t0, int t1, int t2, int t3, int ph);
        int c[4];
        longint s, d, q;
        case (ph)
            0:       c = '{0, 128, 0, 0};
            1:       c = '{-9, 111, 29, -3};
            2:       c = '{-8, 72, 72, -8};
            default: c = '{-3, 29, 111, -9};
        endcase
        s = longint'(t0) * c[0] + longint'(t1) * c[1] + longint'(t2) * c[2] + longint'(t3) * c[3];
`ifdef Y_WEIGHT_ROUND_EN
        s = s + (longint'(1) << (FRAC_IN + 6));
`endif
        d = longint'(1) << (FRAC_IN + 7);
        if (s >= 0) q = s / d;
        else        q = -((-s + d - 1) / d);
        if (q < 0)         q = 0;
        else if (q > MAXO) q = MAXO;
        return int'(q);
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: checks every cycle at the falling edge against the model queue.
    always @(negedge clk) begin
        if (!rst) begin
            check("reset_out_valid", longint'(out_valid), 0);
            check("reset_weight_sum", longint'(weight_sum), 0);
            check("reset_in_ready", longint'(in_ready), 0);
            exp_q.delete();
            stall_pend = 1'b0;
        end else begin
            check("in_ready_rule", longint'(in_ready),
                  (exp_q.size() == 3 && out_valid && !out_ready) ? 0 : 1);
            if (out_valid && exp_q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end
            if (stall_pend) begin
                check("stall_valid_hold", longint'(out_valid), 1);
                check("stall_data_hold", longint'(weight_sum), longint'(stall_val));
            end
            stall_pend = out_valid && !out_ready;
            stall_val  = weight_sum;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                check("result_order_value", longint'(weight_sum), longint'(exp_q.pop_front()));
                pops++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_f(int'(in_0), int'(in_1), int'(in_2), int'(in_3), int'(phase)));
            end
        end
    end

    // One cycle of stimulus, entered and left at rising edge + 1.
    task automatic cyc_drive(input bit v, input bit ordy, input int t0, input int t1,
                             input int t2, input int t3, input int ph, output bit acc);
        in_valid  = v;
        out_ready = ordy;
        in_0 = IN_W'(t0); in_1 = IN_W'(t1); in_2 = IN_W'(t2); in_3 = IN_W'(t3);
        phase = 2'(ph);
        @(negedge clk);
        acc = v && in_ready;
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_tap();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 0;
        if (r == 1) return TMAX;
        return int'($urandom_range(0, TMAX));
    endfunction

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cyc_drive(1'b0, 1'b1, 0, 0, 0, 0, 0, a);
    endtask

    // Single set into an empty pipeline: result exactly 3 cycles after acceptance.
    task automatic directed(input string name, input int t0, input int t1, input int t2,
                            input int t3, input int ph, input int lit);
        idle(4);
        check({name, "_model"}, model_f(t0, t1, t2, t3, ph), lit);
        in_valid = 1'b1; out_ready = 1'b1;
        in_0 = IN_W'(t0); in_1 = IN_W'(t1); in_2 = IN_W'(t2); in_3 = IN_W'(t3);
        phase = 2'(ph);
        @(negedge clk);
        check({name, "_accept"}, longint'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({name, "_early"}, longint'(out_valid), 0);
        @(negedge clk);
        check({name, "_valid"}, longint'(out_valid), 1);
        check({name, "_value"}, longint'(weight_sum), lit);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int cnt, guard, p0;
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("por_out_valid", longint'(out_valid), 0);
        check("por_in_ready", longint'(in_ready), 0);
        #2 rst = 1'b1;
        @(negedge clk);
        check("in_ready_after_release", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        // Directed values
        directed("passthrough", 0, 12800, 0, 0, 0, 100);
        directed("flat_field", 25600, 25600, 25600, 25600, 2, 200);
        directed("low_clamp", 32640, 0, 0, 32640, 2, 0);
        directed("high_clamp", 0, 32640, 32640, 0, 1, 255);
`ifdef Y_WEIGHT_ROUND_EN
        directed("rounding", 0, 64, 0, 0, 0, 1);
`else
        directed("rounding", 0, 64, 0, 0, 0, 0);
`endif

        // Backpressure: 10 sets, out_ready pattern 1,0,0,1
        idle(4);
        p0 = pops; cnt = 0; guard = 0;
        while (cnt < 10 && guard < 200) begin
            cyc_drive(1'b1, pat[guard % 4], rnd_tap(), rnd_tap(), rnd_tap(), rnd_tap(),
                      int'($urandom_range(0, 3)), acc);
            if (acc) cnt++;
            guard++;
        end
        check("bp_accepted", cnt, 10);
        while (pops - p0 < 10 && guard < 300) begin
            cyc_drive(1'b0, pat[guard % 4], 0, 0, 0, 0, 0, acc);
            guard++;
        end
        idle(4);
        check("bp_result_count", pops - p0, 10);

        // Randomized streaming
        for (int i = 0; i < 800; i++) begin
            cyc_drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                      rnd_tap(), rnd_tap(), rnd_tap(), rnd_tap(),
                      int'($urandom_range(0, 3)), acc);
        end
        idle(6);
        check("random_drained", exp_q.size(), 0);

        // Reset with 3 results in flight
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cyc_drive(1'b1, 1'b0, rnd_tap(), rnd_tap(), rnd_tap(), rnd_tap(),
                      int'($urandom_range(0, 3)), acc);
            if (acc) cnt++;
        end
        in_valid = 1'b0;
        check("inflight_accepted", cnt, 3);
        check("inflight_out_valid", longint'(out_valid), 1);
        #1 rst = 1'b0;
        #1;
        check("midreset_out_valid", longint'(out_valid), 0);
        check("midreset_in_ready", longint'(in_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        check("midreset_release_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        p0 = pops;
        idle(6);
        check("no_stale_result", pops - p0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
